// File: rtl/uart_message_link.sv
// Full-duplex UART message link: serialises a MSG_BYTES-wide message as back-to-back
// frames on TX and reassembles MSG_BYTES received frames into Message_out.
module uart_message_link #(
    parameter int unsigned MSG_BYTES    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic                   clk_Device,
    input  logic                   Reset_Device,
    input  logic                   load_message,
    input  logic [8*MSG_BYTES-1:0] Message_in,
    input  logic                   RX,
    output logic                   TX,
    output logic                   tx_busy,
    output logic [8*MSG_BYTES-1:0] Message_out,
    output logic                   message_valid,
    output logic                   frame_error,
    output logic                   parity_error
);

    localparam int unsigned W         = 8 * MSG_BYTES;
    localparam int unsigned CW        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW        = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TW        = $clog2(TO_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(MSG_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [BW-1:0]   tx_byte_q, tx_byte_d;
    logic [W-1:0]    tx_msg_q, tx_msg_d;
    logic            tx_q, tx_d;
    logic            tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk_Device) begin
        if (Reset_Device) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_msg_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_msg_q   <= tx_msg_d;
            tx_q       <= tx_d;
        end
    end

    // The line value is registered one state ahead so each bit lasts exactly
    // CLKS_PER_BIT cycles; the current byte always sits in tx_msg_q[7:0].
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_msg_d   = tx_msg_q;
        tx_d       = tx_q;
        if (tx_state_q != T_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            T_IDLE: begin
                tx_d = 1'b1;
                if (load_message) begin
                    tx_msg_d   = Message_in;
                    tx_byte_d  = '0;
                    tx_cnt_d   = '0;
                    tx_state_d = T_START;
                    tx_d       = 1'b0;
                end
            end
            T_START: begin
                if (tx_bit_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = T_DATA;
                    tx_d       = tx_msg_q[0];
                end
            end
            T_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == 3'd7) begin
                        if (PAR_EN) begin
                            tx_state_d = T_PARITY;
                            tx_d       = (^tx_msg_q[7:0]) ^ PAR_ODD;
                        end else begin
                            tx_state_d = T_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_d     = tx_msg_q[tx_bit_q + 3'd1];
                    end
                end
            end
            T_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = T_STOP;
                    tx_d       = 1'b1;
                end
            end
            T_STOP: begin
                if (tx_bit_end) begin
                    if (tx_byte_q == BYTE_LAST) begin
                        tx_state_d = T_IDLE;
                        tx_d       = 1'b1;
                    end else begin
                        tx_byte_d  = tx_byte_q + 1'b1;
                        tx_msg_d   = tx_msg_q >> 8;
                        tx_state_d = T_START;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    assign TX      = tx_q;
    assign tx_busy = (tx_state_q != T_IDLE);

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;

    rx_state_t       rx_state_q, rx_state_d;
    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_par_bad_q, rx_par_bad_d;
    logic [BW-1:0]   rx_idx_q, rx_idx_d;
    logic [W-1:0]    rx_buf_q, rx_buf_d;
    logic [TW-1:0]   rx_to_q, rx_to_d;
    logic [W-1:0]    msg_out_q, msg_out_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            perr_q, perr_d;
    logic            rx_bit_end;

    assign rx_bit_end = (rx_cnt_q == BIT_LAST);

    always_ff @(posedge clk_Device) begin
        if (Reset_Device) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_state_q   <= R_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_bad_q <= 1'b0;
            rx_idx_q     <= '0;
            rx_buf_q     <= '0;
            rx_to_q      <= '0;
            msg_out_q    <= '0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            rx_s1_q      <= RX;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_bad_q <= rx_par_bad_d;
            rx_idx_q     <= rx_idx_d;
            rx_buf_q     <= rx_buf_d;
            rx_to_q      <= rx_to_d;
            msg_out_q    <= msg_out_d;
            valid_q      <= valid_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_idx_d     = rx_idx_q;
        rx_buf_d     = rx_buf_q;
        rx_to_d      = '0;
        msg_out_d    = msg_out_q;
        valid_d      = 1'b0;
        ferr_d       = 1'b0;
        perr_d       = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_START;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d     = '0;
                    rx_bit_d     = '0;
                    rx_par_bad_d = 1'b0;
                    rx_state_d   = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
                if (rx_bit_end) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = PAR_EN ? R_PARITY : R_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            R_PARITY: begin
                rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
                if (rx_bit_end) begin
                    rx_par_bad_d = ((^rx_shift_q) ^ rx_s2_q) != PAR_ODD;
                    rx_state_d   = R_STOP;
                end
            end
            R_STOP: begin
                rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
                if (rx_bit_end) begin
                    // A parity fault takes precedence so only one error pulse is raised.
                    if (rx_par_bad_q) begin
                        perr_d   = 1'b1;
                        rx_idx_d = '0;
                    end else if (!rx_s2_q) begin
                        ferr_d   = 1'b1;
                        rx_idx_d = '0;
                    end else begin
                        rx_buf_d[{rx_idx_q, 3'b000} +: 8] = rx_shift_q;
                        if (rx_idx_q == BYTE_LAST) begin
                            rx_idx_d  = '0;
                            msg_out_d = rx_buf_d;
                            valid_d   = 1'b1;
                        end else begin
                            rx_idx_d = rx_idx_q + 1'b1;
                        end
                    end
                    rx_state_d = rx_s2_q ? R_IDLE : R_WAIT;
                end
            end
            R_WAIT: begin
                if (rx_s2_q) begin
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
        if (rx_state_q == R_IDLE && rx_idx_q != '0) begin
            if (rx_to_q == TO_LAST) begin
                rx_idx_d = '0;
            end else begin
                rx_to_d = rx_to_q + 1'b1;
            end
        end
    end

    assign Message_out   = msg_out_q;
    assign message_valid = valid_q;
    assign frame_error   = ferr_q;
    assign parity_error  = perr_q;

endmodule

// File: tb/tb_uart_message_link.sv
// Scoreboard bench: dut_a (no parity) and dut_b (odd parity), both 2-byte messages at 4 clk/bit.
module tb_uart_message_link;

    localparam int CPB = 4;
    localparam int TOB = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, load_a, load_b;
    logic [15:0] min_a, min_b, mout_a, mout_b;
    logic        rx_a, rx_b, tx_a, tx_b, busy_a, busy_b;
    logic        val_a, val_b, fe_a, fe_b, pe_a, pe_b;
    logic        loop_a, loop_b, brx_a, brx_b;

    assign rx_a = loop_a ? tx_a : brx_a;
    assign rx_b = loop_b ? tx_b : brx_b;

    uart_message_link #(.MSG_BYTES(2), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0),
                        .TIMEOUT_BITS(TOB)) dut_a (
        .clk_Device(clk), .Reset_Device(rst_a), .load_message(load_a), .Message_in(min_a),
        .RX(rx_a), .TX(tx_a), .tx_busy(busy_a), .Message_out(mout_a),
        .message_valid(val_a), .frame_error(fe_a), .parity_error(pe_a));

    uart_message_link #(.MSG_BYTES(2), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1),
                        .TIMEOUT_BITS(TOB)) dut_b (
        .clk_Device(clk), .Reset_Device(rst_b), .load_message(load_b), .Message_in(min_b),
        .RX(rx_b), .TX(tx_b), .tx_busy(busy_b), .Message_out(mout_b),
        .message_valid(val_b), .frame_error(fe_b), .parity_error(pe_b));

    // kind: 0 message_valid, 1 frame_error, 2 parity_error
    typedef struct {
        int          kind;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_a[$], exp_b[$];
    logic [7:0]  part_a[$], part_b[$];
    logic [15:0] last_a = '0, last_b = '0;
    int          acc_a = 0, acc_b = 0;
    int          n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic get_tx(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic int q_size(input int w);
        return (w == 0) ? exp_a.size() : exp_b.size();
    endfunction

    task automatic push_ev(input int w, input int kind, input logic [15:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        if (w == 0) begin
            exp_a.push_back(e);
            if (kind == 0) last_a = data;
        end else begin
            exp_b.push_back(e);
            if (kind == 0) last_b = data;
        end
    endtask

    // Reference model of the receiver: bytes collect into a message, errors and long idles discard it.
    task automatic model_byte(input int w, input logic [7:0] b, input int kind);
        if (w == 0) acc_a = 0; else acc_b = 0;
        if (kind != 0) begin
            if (w == 0) part_a.delete(); else part_b.delete();
            push_ev(w, kind, 16'h0000);
        end else if (w == 0) begin
            part_a.push_back(b);
            if (part_a.size() == 2) begin
                push_ev(0, 0, {part_a[1], part_a[0]});
                part_a.delete();
            end
        end else begin
            part_b.push_back(b);
            if (part_b.size() == 2) begin
                push_ev(1, 0, {part_b[1], part_b[0]});
                part_b.delete();
            end
        end
    endtask

    task automatic model_idle(input int w, input int nbits);
        if (w == 0) begin
            acc_a += nbits;
            if (acc_a >= TOB) part_a.delete();
        end else begin
            acc_b += nbits;
            if (acc_b >= TOB) part_b.delete();
        end
    endtask

    task automatic drive_bit(input int w, input logic v);
        if (w == 0) brx_a = v; else brx_b = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic drive_idle(input int w, input int nbits);
        model_idle(w, nbits);
        if (w == 0) brx_a = 1'b1; else brx_b = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic drive_byte(input int w, input logic [7:0] b, input int kind);
        logic par;
        model_byte(w, b, kind);
        drive_bit(w, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w, b[i]);
        if (w == 1) begin
            par = ~(^b);
            if (kind == 2) par = ~par;
            drive_bit(w, par);
        end
        drive_bit(w, (kind == 1) ? 1'b0 : 1'b1);
        if (kind == 1) drive_idle(w, 2);
    endtask

    function automatic logic exp_tx_bit(input logic [15:0] m, input int j, input int pen);
        int nb, bp, bi, b;
        logic [7:0] d;
        nb = 10 + pen;
        bp = j / CPB;
        bi = bp / nb;
        b  = bp % nb;
        d  = (bi == 0) ? m[7:0] : m[15:8];
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen == 1 && b == 9) return ~(^d);
        return 1'b1;
    endfunction

    // Loopback send; an extra load_message is pulsed at busy cycle extra_at (if >= 0).
    task automatic send_tx(input int w, input logic [15:0] m, input int extra_at);
        int total, j, werr;
        total = 2 * (10 + w) * CPB;
        if (w == 0) begin loop_a = 1'b1; load_a = 1'b1; min_a = m; end
        else begin loop_b = 1'b1; load_b = 1'b1; min_b = m; end
        push_ev(w, 0, m);
        @(negedge clk);
        if (w == 0) load_a = 1'b0; else load_b = 1'b0;
        check("tx_start_low", get_tx(w), 0);
        check("tx_busy_rise", get_busy(w), 1);
        j = 0;
        werr = 0;
        while (get_busy(w) && j < total + 40) begin
            if (get_tx(w) !== exp_tx_bit(m, j, w)) werr++;
            if (w == 0) begin load_a = (j == extra_at); min_a = (j == extra_at) ? 16'hFFFF : m; end
            else begin load_b = (j == extra_at); min_b = (j == extra_at) ? 16'hFFFF : m; end
            j++;
            @(negedge clk);
        end
        if (w == 0) load_a = 1'b0; else load_b = 1'b0;
        check("tx_busy_cycles", j, total);
        check("tx_waveform_errors", werr, 0);
        check("tx_idle_high", get_tx(w), 1);
    endtask

    task automatic drain(input int w);
        int t;
        t = 0;
        while (q_size(w) != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", q_size(w), 0);
    endtask

    task automatic mon_event(input int w, input logic v, input logic fe, input logic pe,
                             input logic [15:0] mo);
        ev_t e;
        int k;
        k = v ? 0 : (fe ? 1 : 2);
        check("one_flag_per_event", 32'(v) + 32'(fe) + 32'(pe), 1);
        if (q_size(w) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event dut%0d: got kind %0d, expected none", w, k);
        end else begin
            if (w == 0) e = exp_a.pop_front(); else e = exp_b.pop_front();
            check("event_kind", k, e.kind);
            if (e.kind == 0) check("message_out", mo, e.data);
        end
    endtask

    always @(negedge clk) if (val_a || fe_a || pe_a) mon_event(0, val_a, fe_a, pe_a, mout_a);
    always @(negedge clk) if (val_b || fe_b || pe_b) mon_event(1, val_b, fe_b, pe_b, mout_b);

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n;
        logic [15:0] m;
        rst_a = 1'b1; rst_b = 1'b1; load_a = 1'b0; load_b = 1'b0;
        min_a = '0; min_b = '0; loop_a = 1'b1; loop_b = 1'b1; brx_a = 1'b1; brx_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {tx_a, tx_b}, 2'b11);
        check("reset_busy", {busy_a, busy_b}, 2'b00);
        check("reset_msg_out", {mout_a, mout_b}, 32'h0);
        check("reset_flags", {val_a, fe_a, pe_a, val_b, fe_b, pe_b}, 6'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        send_tx(0, 16'hA55A, -1);
        drain(0);
        check("loop_a55a", mout_a, 16'hA55A);

        send_tx(1, 16'h0701, -1);
        drain(1);
        check("loop_parity_0701", mout_b, 16'h0701);
        loop_b = 1'b0;
        drive_byte(1, 8'h01, 0);
        drive_byte(1, 8'h07, 2);
        drain(1);
        check("parity_err_holds_msg", mout_b, 16'h0701);

        loop_a = 1'b0;
        drive_byte(0, 8'h12, 1);
        drive_byte(0, 8'h34, 0);
        drive_byte(0, 8'h56, 0);
        drain(0);
        check("frame_err_then_msg", mout_a, 16'h5634);

        drive_byte(0, 8'h11, 0);
        drive_idle(0, 21);
        drive_byte(0, 8'hBE, 0);
        drive_byte(0, 8'hEF, 0);
        drain(0);
        check("timeout_then_msg", mout_a, 16'hEFBE);

        brx_a = 1'b0;
        @(negedge clk);
        brx_a = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_holds_msg", mout_a, 16'hEFBE);
        drive_byte(0, 8'h5A, 0);
        drive_byte(0, 8'hC3, 0);
        drain(0);

        send_tx(0, 16'h3C96, 10);
        drain(0);
        check("ignored_reload", mout_a, 16'h3C96);

        for (int i = 0; i < 4; i++) begin
            m = 16'($urandom);
            send_tx(0, m, -1);
            m = 16'($urandom);
            send_tx(1, m, -1);
            drain(0);
            drain(1);
        end

        loop_a = 1'b0;
        loop_b = 1'b0;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 30; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 6) drive_byte(w, 8'($urandom), 0);
                else if (r == 6) drive_byte(w, 8'($urandom), 1);
                else if (r == 7) drive_byte(w, 8'($urandom), (w == 1) ? 2 : 0);
                else if (r == 8) drive_idle(w, int'($urandom_range(22, 26)));
                else begin
                    n = int'($urandom_range(0, 3));
                    if (((w == 0) ? acc_a : acc_b) + n > 12) n = 0;
                    drive_idle(w, n);
                end
            end
            drive_idle(w, 24);
            drain(w);
            check("stream_msg_hold", (w == 0) ? mout_a : mout_b, (w == 0) ? last_a : last_b);
        end

        loop_a = 1'b1;
        load_a = 1'b1;
        min_a = 16'h1234;
        @(negedge clk);
        load_a = 1'b0;
        repeat (29) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check("midsend_reset_tx", tx_a, 1);
        check("midsend_reset_busy", busy_a, 0);
        check("midsend_reset_msg", mout_a, 16'h0000);
        rst_a = 1'b0;
        last_a = '0;
        part_a.delete();
        repeat (120) @(negedge clk);
        check("post_reset_idle", {busy_a, tx_a}, 2'b01);
        check("post_reset_msg", mout_a, last_a);
        check("final_queues", q_size(0) + q_size(1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
